// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an 8-bit fifo read port and serialises them
// LSB first with optional parity and 1 or 2 stop bits; tx idles high.
module fifo_uart_tx #(
    parameter int unsigned ClksPerBit = 868,
    parameter int unsigned Parity     = 0,
    parameter int unsigned StopBits   = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_dout_i,
    output logic       fifo_rd_en_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic            tx_q;
    logic            rd_en_q;
    logic            done_q;
    logic            baud_end;

    assign baud_end = (cnt_q == CntW'(ClksPerBit - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            rd_en_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    tx_q  <= 1'b1;
                    cnt_q <= '0;
                    if (enable_i && !fifo_empty_i) begin
                        state_q <= StFetch;
                        rd_en_q <= 1'b1;
                    end
                end
                StFetch: begin
                    state_q <= StLoad;
                end
                StLoad: begin
                    shift_q  <= fifo_dout_i;
                    parity_q <= (^fifo_dout_i) ^ (Parity == 2);
                    tx_q     <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= StStart;
                end
                StStart: begin
                    if (baud_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            bit_q <= '0;
                            if (Parity != 0) begin
                                tx_q    <= parity_q;
                                state_q <= StParity;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    if (baud_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'(StopBits - 1)) begin
                            bit_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        // Raise the pulse so it lands on the very last stop cycle.
                        if (cnt_q == CntW'(ClksPerBit - 2) && bit_q == 3'(StopBits - 1)) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign fifo_rd_en_o = rd_en_q;
    assign tx_o         = tx_q;
    assign busy_o       = (state_q != StIdle);
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench: three transmitters (no parity / even+2 stop / odd) each fed by a queue fifo,
// checked every cycle against a frame-timing reference model.
module tb_fifo_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] empty = 3'b111;
    logic [7:0] dout [3];
    logic [2:0] rd_en, tx, busy, done;

    bit [7:0] fq [3][$];
    bit [7:0] rq [3][$];
    bit [7:0] decoded [3][$];
    int  active [3];
    int  t [3];
    bit [7:0] cur [3];
    logic [11:0] samp [3];
    int  rd_cnt [3], done_cnt [3], busy_cyc [3];
    int  last_rd_cyc [3], last_done_cyc [3];
    int  gaps [$];
    logic [2:0] prev_tx = 3'b111;
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.ClksPerBit(C), .Parity(0), .StopBits(1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .fifo_empty_i(empty[0]),
        .fifo_dout_i(dout[0]), .fifo_rd_en_o(rd_en[0]), .tx_o(tx[0]), .busy_o(busy[0]),
        .frame_done_o(done[0])
    );
    fifo_uart_tx #(.ClksPerBit(C), .Parity(1), .StopBits(2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .fifo_empty_i(empty[1]),
        .fifo_dout_i(dout[1]), .fifo_rd_en_o(rd_en[1]), .tx_o(tx[1]), .busy_o(busy[1]),
        .frame_done_o(done[1])
    );
    fifo_uart_tx #(.ClksPerBit(C), .Parity(2), .StopBits(1)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .fifo_empty_i(empty[2]),
        .fifo_dout_i(dout[2]), .fifo_rd_en_o(rd_en[2]), .tx_o(tx[2]), .busy_o(busy[2]),
        .frame_done_o(done[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int par_cfg(input int i);
        return i;
    endfunction

    function automatic int stop_cfg(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    // Cycles from the IDLE decision edge until IDLE is re-entered.
    function automatic int frame_len(input int i);
        return 2 + C * (10 + ((par_cfg(i) != 0) ? 1 : 0) + stop_cfg(i) - 1);
    endfunction

    // Expected {tx, busy, rd_en, frame_done} for the current cycle.
    function automatic logic [3:0] expect_out(input int i);
        int b;
        logic txe;
        if (active[i] == 0) return 4'b1000;
        if (t[i] < 2) begin
            txe = 1'b1;
        end else begin
            b = (t[i] - 2) / C;
            if (b == 0) txe = 1'b0;
            else if (b <= 8) txe = cur[i][b-1];
            else if (b == 9 && par_cfg(i) != 0) txe = (par_cfg(i) == 1) ? ^cur[i] : ~^cur[i];
            else txe = 1'b1;
        end
        return {txe, 1'b1, (t[i] == 0), (t[i] == frame_len(i) - 1)};
    endfunction

    task automatic push(input int i, input bit [7:0] b);
        fq[i].push_back(b);
        rq[i].push_back(b);
        empty[i] = 1'b0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            rd_cnt[i] = 0;
            done_cnt[i] = 0;
            busy_cyc[i] = 0;
            decoded[i].delete();
        end
        gaps.delete();
    endtask

    task automatic tick();
        int b;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (rst_n) begin
                if (active[i] != 0) begin
                    t[i]++;
                    if (t[i] == frame_len(i)) active[i] = 0;
                end else if (enable && !empty[i]) begin
                    active[i] = 1;
                    t[i] = 0;
                    cur[i] = (rq[i].size() > 0) ? rq[i].pop_front() : 8'h00;
                    samp[i] = '1;
                end
            end
            check($sformatf("out%0d_c%0d", i, cyc), {28'd0, tx[i], busy[i], rd_en[i], done[i]},
                  {28'd0, expect_out(i)});
            if (active[i] != 0 && t[i] >= 2 && ((t[i] - 2) % C) == C / 2) begin
                b = (t[i] - 2) / C;
                if (b < 12) samp[i][b] = tx[i];
            end
            if (active[i] != 0 && t[i] == frame_len(i) - 1) decoded[i].push_back(samp[i][8:1]);
            if (rd_en[i]) begin
                rd_cnt[i]++;
                last_rd_cyc[i] = cyc;
            end
            if (done[i]) begin
                done_cnt[i]++;
                last_done_cyc[i] = cyc;
            end
            if (busy[i]) busy_cyc[i]++;
            if (i == 0 && prev_tx[0] && !tx[0] && last_rd_cyc[0] == cyc - 2 && done_cnt[0] > 0)
                gaps.push_back(cyc - last_done_cyc[0]);
            prev_tx[i] = tx[i];
            if (rd_en[i] && fq[i].size() > 0) dout[i] = fq[i].pop_front();
            empty[i] = (fq[i].size() == 0);
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 3; i++) begin
            dout[i] = 8'h00;
            active[i] = 0;
            t[i] = 0;
            samp[i] = '1;
            last_rd_cyc[i] = -10;
            last_done_cyc[i] = -10;
        end
        clear_counts();

        // Reset hold with non-empty fifos and enable high.
        enable = 1'b1;
        push(0, 8'hA5);
        push(1, 8'h07);
        push(2, 8'h07);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (60) tick();
        check("a5_bits", {22'd0, samp[0][9:0]}, 32'h34A);
        check("a5_rd_cnt", rd_cnt[0], 1);
        check("a5_done_cnt", done_cnt[0], 1);
        check("a5_done_pos", last_done_cyc[0] - last_rd_cyc[0], 41);
        check("a5_busy_cycles", busy_cyc[0], 42);
        check("even_parity_bit", samp[1][9], 1);
        check("odd_parity_bit", samp[2][9], 0);
        check("stop2_busy_cycles", busy_cyc[1], 50);
        check("odd_busy_cycles", busy_cyc[2], 46);

        // Back-to-back stream.
        clear_counts();
        push(0, 8'hFF);
        push(0, 8'hFE);
        push(0, 8'h11);
        for (int k = 0; k < 3; k++) push(1 + (k % 2), 8'($urandom));
        repeat (200) tick();
        check("stream_rd_cnt", rd_cnt[0], 3);
        check("stream_frames", decoded[0].size(), 3);
        if (decoded[0].size() == 3) begin
            check("stream_b0", decoded[0][0], 8'hFF);
            check("stream_b1", decoded[0][1], 8'hFE);
            check("stream_b2", decoded[0][2], 8'h11);
        end
        check("stream_gap_count", gaps.size(), 2);
        foreach (gaps[g]) check($sformatf("stream_gap%0d", g), gaps[g], 4);
        check("stream_empty", empty[0], 1);
        check("stream_busy", busy[0], 0);

        // Enable dropped during data bit 3 of the first of two frames.
        clear_counts();
        push(0, 8'h3C);
        push(0, 8'hC3);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (active[0] != 0 && t[0] == 2 + 4 * C + 1) found = 1'b1;
        end
        check("wait_data_bit3", found, 1);
        enable = 1'b0;
        repeat (80) tick();
        check("endrop_rd_cnt", rd_cnt[0], 1);
        check("endrop_done_cnt", done_cnt[0], 1);
        check("endrop_left", fq[0].size(), 1);
        enable = 1'b1;
        tick();
        check("endrop_fetch", rd_en[0], 1);
        tick();
        check("endrop_load_tx", tx[0], 1);
        tick();
        check("endrop_start_tx", tx[0], 0);
        repeat (60) tick();

        // Asynchronous reset during data bit 5.
        clear_counts();
        push(0, 8'h5A);
        push(0, 8'h96);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (active[0] != 0 && t[0] == 2 + 6 * C + 1) found = 1'b1;
        end
        check("wait_data_bit5", found, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx[0], 1);
        check("async_rst_busy", busy[0], 0);
        for (int i = 0; i < 3; i++) active[i] = 0;
        clear_counts();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (60) tick();
        check("post_rst_rd_cnt", rd_cnt[0], 1);
        check("post_rst_frames", decoded[0].size(), 1);
        if (decoded[0].size() == 1) check("post_rst_byte", decoded[0][0], 8'h96);

        // Random traffic and enable toggling.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 47) == 0) push(int'($urandom_range(0, 2)), 8'($urandom));
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            tick();
        end
        enable = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            tick();
            if (empty == 3'b111 && active[0] == 0 && active[1] == 0 && active[2] == 0)
                found = 1'b1;
        end
        check("drain_done", found, 1);
        tick();
        check("final_busy", {29'd0, busy}, 0);
        check("final_empty", {29'd0, empty}, 32'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
